// File: rtl/serial_mul.sv
// serial_mul: bit-serial unsigned multiplier, one radix-2 shift-and-add step
// per clock.
//
// Each operand channel uses a valid/ready handshake, and so does the result
// channel. The two operands may arrive in either order or together. Once
// both are held, the block runs for exactly WIDTH cycles. It then presents
// the full-precision 2*WIDTH-bit product until the consumer takes it.
//
// Ports
//   clk         in   1          clock, rising edge
//   asyn_reset  in   1          asynchronous active-high reset
//   x           in   WIDTH      multiplicand (unsigned)
//   y           in   WIDTH      multiplier (unsigned)
//   product     out  2*WIDTH    x*y, registered
//   data_x_vld  in   1          x valid
//   data_x_rdy  out  1          block can accept x
//   data_y_vld  in   1          y valid
//   data_y_rdy  out  1          block can accept y
//   d_out_vld   out  1          product valid
//   d_out_rdy   in   1          consumer accepts product
module serial_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   product,
  input  logic                 data_x_vld,
  output logic                 data_x_rdy,
  input  logic                 data_y_vld,
  output logic                 data_y_rdy,
  output logic                 d_out_vld,
  input  logic                 d_out_rdy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {COLLECT, BUSY, DONE} state_t;

  state_t               state, state_next;
  logic                 x_held, x_held_next;
  logic                 y_held, y_held_next;
  logic [WIDTH-1:0]     mcand, mcand_next;
  logic [WIDTH-1:0]     mplr, mplr_next;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [2*WIDTH-1:0]   product_next;
  logic                 vld_next;

  logic                 x_take, y_take;
  logic [2*WIDTH-1:0]   addend, acc_sum;

  // The ready signals are decoded from registered state only, so they never
  // form a combinational path from the valid inputs.
  assign data_x_rdy = (state == COLLECT) && !x_held;
  assign data_y_rdy = (state == COLLECT) && !y_held;

  assign x_take = data_x_vld && data_x_rdy;
  assign y_take = data_y_vld && data_y_rdy;

  // Partial product for the current bit position. The accumulator is
  // 2*WIDTH bits wide, so (2^WIDTH-1)^2 fits and no overflow can occur.
  assign addend  = {{WIDTH{1'b0}}, mcand} << cnt;
  assign acc_sum = mplr[0] ? (acc + addend) : acc;

  always_comb begin
    state_next   = state;
    x_held_next  = x_held;
    y_held_next  = y_held;
    mcand_next   = mcand;
    mplr_next    = mplr;
    acc_next     = acc;
    cnt_next     = cnt;
    product_next = product;
    vld_next     = d_out_vld;

    case (state)
      COLLECT: begin
        if (x_take) begin
          x_held_next = 1'b1;
          mcand_next  = x;
        end
        if (y_take) begin
          y_held_next = 1'b1;
          mplr_next   = y;
        end
        // Start as soon as both operands are held after this edge, whether
        // they arrived together or one was already waiting.
        if ((x_held || x_take) && (y_held || y_take)) begin
          state_next = BUSY;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end

      BUSY: begin
        acc_next  = acc_sum;
        mplr_next = mplr >> 1;
        cnt_next  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          product_next = acc_sum;
          vld_next     = 1'b1;
          state_next   = DONE;
        end
      end

      DONE: begin
        if (d_out_rdy) begin
          vld_next    = 1'b0;
          x_held_next = 1'b0;
          y_held_next = 1'b0;
          state_next  = COLLECT;
        end
      end

      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state     <= COLLECT;
      x_held    <= 1'b0;
      y_held    <= 1'b0;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      d_out_vld <= 1'b0;
    end else begin
      state     <= state_next;
      x_held    <= x_held_next;
      y_held    <= y_held_next;
      mcand     <= mcand_next;
      mplr      <= mplr_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      product   <= product_next;
      d_out_vld <= vld_next;
    end
  end

endmodule
